// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier control unit.
package booth_pkg;

    localparam int unsigned OP_W        = 3;
    localparam int unsigned N_STEPS_DEF = 3;

    // Booth pair {Q0, Q(-1)} codes that need an add or subtract of M
    localparam logic [1:0] PAIR_ADD = 2'b01;
    localparam logic [1:0] PAIR_SUB = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_INIT  = 3'd2,
        ST_STEP  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/booth_step_cnt.sv
// Booth iteration counter: clear, count enable and last-step flag.
module booth_step_cnt #(
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned N_STEPS = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic last_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_c = (cnt_q == CNT_W'(N_STEPS - 1));

endmodule

// File: rtl/booth_uc.sv
// Booth multiplier control unit: sequences clear, init and N_STEPS
// add/sub-and-shift or shift-only strobes for the downstream datapath.
// Optional build macro BOOTH_UC_SKIP_ZERO_EN: a zero operand goes from
// CLEAR straight to DONE, relying on the clear to leave a zero result.
module booth_uc
    import booth_pkg::*;
#(
    parameter int unsigned N_STEPS = N_STEPS_DEF,
    parameter int unsigned CNT_W   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [OP_W-1:0] multiplicand,
    input  logic [OP_W-1:0] multiplier,
    input  logic [2:0]      q_uc,
    output logic            dp_clr,
    output logic            init_uc,
    output logic [OP_W-1:0] M_uc,
    output logic [OP_W-1:0] Q_uc,
    output logic            loadA_uc,
    output logic            sum_uc,
    output logic            shift_uc,
    output logic            busy,
    output logic            done
);

    state_e          state_q;
    state_e          state_d;
    logic [OP_W-1:0] m_op_q;
    logic [OP_W-1:0] m_op_d;
    logic [OP_W-1:0] q_op_q;
    logic [OP_W-1:0] q_op_d;
    logic            dp_clr_q;
    logic            dp_clr_d;
    logic            init_q;
    logic            init_d;
    logic            busy_q;
    logic            busy_d;
    logic            done_q;
    logic            done_d;
    logic            sum_idle_q;
    logic            sum_idle_d;
    logic            cnt_clr;
    logic            cnt_en;
    logic            cnt_last_c;
    logic [1:0]      pair_c;
    logic            q_uc_unused;

    assign pair_c      = q_uc[1:0];
    assign q_uc_unused = q_uc[2];

    booth_step_cnt #(
        .CNT_W   (CNT_W),
        .N_STEPS (N_STEPS)
    ) u_step_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .last_c (cnt_last_c)
    );

    // Next-state, operand capture and registered strobe decode
    always_comb begin
        state_d    = state_q;
        m_op_d     = m_op_q;
        q_op_d     = q_op_q;
        sum_idle_d = sum_idle_q;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_op_d     = multiplicand;
                    q_op_d     = multiplier;
                    sum_idle_d = 1'b1;
                    state_d    = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
`ifdef BOOTH_UC_SKIP_ZERO_EN
                if ((m_op_q == '0) || (q_op_q == '0)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_INIT;
                end
`else
                state_d = ST_INIT;
`endif
            end
            ST_INIT: begin
                cnt_clr = 1'b1;
                state_d = ST_STEP;
            end
            ST_STEP: begin
                cnt_en = 1'b1;
                if (cnt_last_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        dp_clr_d = (state_d == ST_CLEAR);
        init_d   = (state_d == ST_INIT);
        done_d   = (state_d == ST_DONE);
        busy_d   = (state_d != ST_IDLE);
    end

    // State, operand and strobe registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            m_op_q     <= '0;
            q_op_q     <= '0;
            dp_clr_q   <= 1'b0;
            init_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sum_idle_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_op_q     <= m_op_d;
            q_op_q     <= q_op_d;
            dp_clr_q   <= dp_clr_d;
            init_q     <= init_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sum_idle_q <= sum_idle_d;
        end
    end

    // Booth pair decode in STEP; outside STEP sum_uc rests at add, except
    // after reset where it stays low until the first accepted start
    always_comb begin
        loadA_uc = 1'b0;
        shift_uc = 1'b0;
        sum_uc   = sum_idle_q;
        if (state_q == ST_STEP) begin
            case (pair_c)
                PAIR_ADD: begin
                    loadA_uc = 1'b1;
                    sum_uc   = 1'b1;
                end
                PAIR_SUB: begin
                    loadA_uc = 1'b1;
                    sum_uc   = 1'b0;
                end
                default: begin
                    shift_uc = 1'b1;
                    sum_uc   = 1'b1;
                end
            endcase
        end
    end

    assign dp_clr  = dp_clr_q;
    assign init_uc = init_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign M_uc    = m_op_q;
    assign Q_uc    = q_op_q;

endmodule

// File: tb/tb_booth_uc.sv
// Bench for booth_uc with a behavioural 3-bit Booth datapath closing the loop.
module tb_booth_uc;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] multiplicand;
    logic [2:0] multiplier;
    logic [2:0] q_uc;
    logic       dp_clr;
    logic       init_uc;
    logic [2:0] M_uc;
    logic [2:0] Q_uc;
    logic       loadA_uc;
    logic       sum_uc;
    logic       shift_uc;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_uc dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .q_uc         (q_uc),
        .dp_clr       (dp_clr),
        .init_uc      (init_uc),
        .M_uc         (M_uc),
        .Q_uc         (Q_uc),
        .loadA_uc     (loadA_uc),
        .sum_uc       (sum_uc),
        .shift_uc     (shift_uc),
        .busy         (busy),
        .done         (done)
    );

    // Datapath model: A and sum are computed one bit wider so -4 * -4 works
    logic [2:0] a_r;
    logic [2:0] q_r;
    logic       q1_r;
    logic [2:0] m_r;
    logic [3:0] sum4;
    logic [5:0] result;

    always_comb begin
        if (sum_uc) sum4 = {a_r[2], a_r} + {m_r[2], m_r};
        else        sum4 = {a_r[2], a_r} - {m_r[2], m_r};
    end

    always_ff @(posedge clk) begin
        if (reset || dp_clr) begin
            a_r <= 3'b000; q_r <= 3'b000; q1_r <= 1'b0; m_r <= 3'b000;
        end else if (init_uc) begin
            a_r <= 3'b000; q_r <= Q_uc; q1_r <= 1'b0; m_r <= M_uc;
        end else if (loadA_uc) begin
            a_r <= sum4[3:1]; q_r <= {sum4[0], q_r[2:1]}; q1_r <= q_r[0];
        end else if (shift_uc) begin
            a_r <= {a_r[2], a_r[2:1]}; q_r <= {a_r[0], q_r[2:1]}; q1_r <= q_r[0];
        end
    end

    assign q_uc   = {1'b0, q_r[0], q1_r};
    assign result = {a_r, q_r};

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endfunction

    // One multiply from the current negedge (must be IDLE); returns at the
    // negedge after done. Strobe sequence codes: 01 shift, 10 sub, 11 add.
    task automatic run_op(input logic [2:0] m, input logic [2:0] q,
                          input logic [5:0] exp_res, input logic [5:0] exp_seq,
                          input int exp_lat, input int exp_steps, input int exp_init,
                          input bit interfere);
        int k, strobes, both, clr_n, init_n, busy_lo;
        bit seen;
        logic [5:0] seq;
        k = 0; strobes = 0; both = 0; clr_n = 0; init_n = 0; busy_lo = 0;
        seen = 1'b0; seq = 6'b0;
        multiplicand = m; multiplier = q; start = 1'b1;
        @(negedge clk);
        start = 1'b0; k = 1;
        while (!seen && k <= 20) begin
            if (loadA_uc && shift_uc) both++;
            if (loadA_uc || shift_uc) begin
                strobes++;
                seq = {seq[3:0], loadA_uc ? (sum_uc ? 2'b11 : 2'b10) : 2'b01};
            end
            if (dp_clr)  clr_n++;
            if (init_uc) init_n++;
            if (!busy)   busy_lo++;
            if (interfere && k == 3) begin
                start = 1'b1; multiplicand = ~m; multiplier = q ^ 3'b101;
            end
            if (interfere && k == 4) begin
                start = 1'b0; multiplicand = m; multiplier = q;
            end
            if (done) seen = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        chk("done_latency", seen ? k : 0, exp_lat);
        chk("result", int'(result), int'(exp_res));
        chk("strobe_seq", int'(seq), int'(exp_seq));
        chk("strobe_count", strobes, exp_steps);
        chk("strobe_overlap", both, 0);
        chk("dp_clr_pulses", clr_n, 1);
        chk("init_pulses", init_n, exp_init);
        chk("busy_low_while_running", busy_lo, 0);
        chk("M_uc_held", int'(M_uc), int'(m));
        chk("Q_uc_held", int'(Q_uc), int'(q));
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);
        chk("busy_after_done", int'(busy), 0);
        chk("result_still_valid", int'(result), int'(exp_res));
    endtask

    typedef struct {
        logic [2:0] m;
        logic [2:0] q;
        logic [5:0] res;
        logic [5:0] seq;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int done_n;
        vecs[0] = '{m: 3'b011, q: 3'b010, res: 6'b000110, seq: 6'b01_10_11}; //  3 *  2
        vecs[1] = '{m: 3'b100, q: 3'b011, res: 6'b110100, seq: 6'b10_01_11}; // -4 *  3
        vecs[2] = '{m: 3'b100, q: 3'b100, res: 6'b010000, seq: 6'b01_01_10}; // -4 * -4
        vecs[3] = '{m: 3'b111, q: 3'b111, res: 6'b000001, seq: 6'b10_01_01}; // -1 * -1

        reset = 1'b1; start = 1'b0; multiplicand = 3'b000; multiplier = 3'b000;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            int'({dp_clr, init_uc, loadA_uc, sum_uc, shift_uc, busy, done, Q_uc, M_uc}), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        // Back-to-back table: each start lands in the IDLE cycle after done
        for (int i = 0; i < 4; i++) begin
            run_op(vecs[i].m, vecs[i].q, vecs[i].res, vecs[i].seq, 6, 3, 1, 1'b0);
        end

        // start re-pulsed during STEP with other operands is ignored
        run_op(3'b011, 3'b010, 6'b000110, 6'b01_10_11, 6, 3, 1, 1'b1);

        // Reset in the second STEP cycle aborts without a done pulse
        @(negedge clk);
        multiplicand = 3'b011; multiplier = 3'b010; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_in_step", int'(loadA_uc | shift_uc), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_outputs",
            int'({dp_clr, init_uc, loadA_uc, sum_uc, shift_uc, busy, done, Q_uc, M_uc}), 0);
        done_n = 0;
        for (int c = 0; c < 8; c++) begin
            if (done || busy) done_n++;
            @(negedge clk);
        end
        chk("no_done_after_abort", done_n, 0);

        run_op(3'b010, 3'b010, 6'b000100, 6'b01_10_11, 6, 3, 1, 1'b0); // 2 * 2

        // 0 * -3
`ifdef BOOTH_UC_SKIP_ZERO_EN
        run_op(3'b000, 3'b101, 6'b000000, 6'b00_00_00, 2, 0, 0, 1'b0);
`else
        run_op(3'b000, 3'b101, 6'b000000, 6'b10_11_10, 6, 3, 1, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
